// File: rtl/l1_stretch_pkg.sv
// Shared types, default widths and helpers for the L1 trigger pulse stretcher.
package l1_stretch_pkg;

  localparam int unsigned NchDef  = 4;
  localparam int unsigned LenWDef = 8;
  localparam int unsigned CntWDef = 16;
  localparam int unsigned MaxCntW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStretch,
    StHoldoff
  } stretch_state_e;

  // Counters narrower than MaxCntW are zero-extended in and truncated out by the caller.
  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] val,
                                                 input logic [MaxCntW-1:0] max_val);
    return (val >= max_val) ? max_val : val + MaxCntW'(1);
  endfunction

endpackage

// File: rtl/l1_stretch_chan.sv
// One trigger channel: edge detect, stretch/holdoff FSM, length counter and
// saturating accepted/dropped statistics.
module l1_stretch_chan
  import l1_stretch_pkg::*;
#(
  parameter int unsigned LEN_W = LenWDef,
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk250,
  input  logic             rst_n,
  input  logic             trig_i,
  input  logic             enable_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [LEN_W-1:0] holdoff_i,
  input  logic             retrig_i,
  input  logic             cnt_clr_i,
  output logic             stretched_o,
  output logic             rise_o,
  output logic [CNT_W-1:0] acc_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam logic [MaxCntW-1:0] CntMax = MaxCntW'({CNT_W{1'b1}});

  stretch_state_e   state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             trig_q;
  logic             stretched_q, stretched_d;
  logic             rise_q, rise_d;
  logic             trig_edge;
  logic             acc_inc, drop_inc;
  logic [LEN_W-1:0] len_m1;

  assign trig_edge = trig_i & ~trig_q;
  // A length of 0 behaves like 1: the shortest pulse is one cycle.
  assign len_m1    = (len_i == '0) ? '0 : len_i - LEN_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_inc  = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_edge && enable_i) begin
          state_d = StStretch;
          cnt_d   = len_m1;
          acc_inc = 1'b1;
        end
      end
      StStretch: begin
        if (trig_edge && retrig_i) begin
          cnt_d   = len_m1;
          acc_inc = 1'b1;
        end else begin
          drop_inc = trig_edge;
          if (cnt_q == '0) begin
            if (holdoff_i == '0) begin
              state_d = StIdle;
            end else begin
              state_d = StHoldoff;
              cnt_d   = holdoff_i - LEN_W'(1);
            end
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      StHoldoff: begin
        drop_inc = trig_edge;
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    if (cnt_clr_i) begin
      acc_d  = '0;
      drop_d = '0;
    end else begin
      if (acc_inc)  acc_d  = CNT_W'(sat_inc(MaxCntW'(acc_q), CntMax));
      if (drop_inc) drop_d = CNT_W'(sat_inc(MaxCntW'(drop_q), CntMax));
    end
  end

  assign stretched_d = (state_d == StStretch);
  assign rise_d      = (state_q == StIdle) && (state_d == StStretch);

  always_ff @(posedge clk250 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      drop_q      <= '0;
      trig_q      <= 1'b0;
      stretched_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      drop_q      <= drop_d;
      trig_q      <= trig_i;
      stretched_q <= stretched_d;
      rise_q      <= rise_d;
    end
  end

  assign stretched_o = stretched_q;
  assign rise_o      = rise_q;
  assign acc_cnt_o   = acc_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: rtl/l1_stretch_multi.sv
// Multi-channel L1 trigger pulse stretcher: NCH independent channels plus a
// registered any-channel-active flag and packed statistics buses.
module l1_stretch_multi
  import l1_stretch_pkg::*;
#(
  parameter int unsigned NCH   = NchDef,
  parameter int unsigned LEN_W = LenWDef,
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic                 clk250,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       trig_i,
  input  logic [NCH-1:0]       enable_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic [LEN_W-1:0]     holdoff_i,
  input  logic                 retrig_i,
  input  logic                 cnt_clr_i,
  output logic [NCH-1:0]       stretched_o,
  output logic [NCH-1:0]       rise_o,
  output logic                 any_o,
  output logic [NCH*CNT_W-1:0] acc_cnt_o,
  output logic [NCH*CNT_W-1:0] drop_cnt_o
);

  logic any_q, any_d;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    l1_stretch_chan #(
      .LEN_W(LEN_W),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk250     (clk250),
      .rst_n      (rst_n),
      .trig_i     (trig_i[k]),
      .enable_i   (enable_i[k]),
      .len_i      (len_i),
      .holdoff_i  (holdoff_i),
      .retrig_i   (retrig_i),
      .cnt_clr_i  (cnt_clr_i),
      .stretched_o(stretched_o[k]),
      .rise_o     (rise_o[k]),
      .acc_cnt_o  (acc_cnt_o[k*CNT_W +: CNT_W]),
      .drop_cnt_o (drop_cnt_o[k*CNT_W +: CNT_W])
    );
  end

  assign any_d = |stretched_o;

  always_ff @(posedge clk250 or negedge rst_n) begin
    if (!rst_n) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign any_o = any_q;

endmodule

// File: tb/tb_l1_stretch_multi.sv
// Bench for l1_stretch_multi: directed timing scenarios plus randomized traffic
// checked against a timeline-based reference model.
module tb_l1_stretch_multi;

  localparam int NCH  = 4;
  localparam int LW   = 8;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk250 = 1'b0;
  logic              rst_n  = 1'b0;
  logic [NCH-1:0]    trig   = '0;
  logic [NCH-1:0]    en     = '1;
  logic [LW-1:0]     len    = '0;
  logic [LW-1:0]     hold   = '0;
  logic              retrig = 1'b0;
  logic              clr    = 1'b0;
  logic [NCH-1:0]    stretched, rise;
  logic              any_out;
  logic [NCH*CW-1:0] acc, drop;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each channel is described by the last cycle of its
  // current stretch and the last cycle of the holdoff following it.
  int             st_end[NCH];
  int             ho_end[NCH];
  int             m_acc[NCH];
  int             m_drop[NCH];
  int             mcyc;
  logic [NCH-1:0] m_prev, m_str, m_rise;
  logic           m_any;

  l1_stretch_multi #(
    .NCH  (NCH),
    .LEN_W(LW),
    .CNT_W(CW)
  ) dut (
    .clk250     (clk250),
    .rst_n      (rst_n),
    .trig_i     (trig),
    .enable_i   (en),
    .len_i      (len),
    .holdoff_i  (hold),
    .retrig_i   (retrig),
    .cnt_clr_i  (clr),
    .stretched_o(stretched),
    .rise_o     (rise),
    .any_o      (any_out),
    .acc_cnt_o  (acc),
    .drop_cnt_o (drop)
  );

  always #5 clk250 = ~clk250;

  function automatic void model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      st_end[ch] = -1;
      ho_end[ch] = -1;
      m_acc[ch]  = 0;
      m_drop[ch] = 0;
    end
    m_prev = '0;
    m_str  = '0;
    m_rise = '0;
    m_any  = 1'b0;
    mcyc   = 0;
  endfunction

  // Consumes the inputs of cycle mcyc and predicts the outputs of cycle mcyc+1.
  function automatic void model_step();
    int lp;
    lp    = (len == '0) ? 1 : int'(len);
    m_any = |m_str;
    for (int ch = 0; ch < NCH; ch++) begin
      logic e, in_st, in_ho, a, d;
      int   t;
      t     = mcyc;
      e     = trig[ch] & ~m_prev[ch];
      in_st = (t <= st_end[ch]);
      in_ho = !in_st && (t <= ho_end[ch]);
      a     = 1'b0;
      d     = 1'b0;
      m_rise[ch] = 1'b0;
      if (e) begin
        if (in_st) begin
          if (retrig) begin
            st_end[ch] = t + lp;
            a = 1'b1;
          end else begin
            d = 1'b1;
          end
        end else if (in_ho) begin
          d = 1'b1;
        end else if (en[ch]) begin
          st_end[ch] = t + lp;
          a = 1'b1;
          m_rise[ch] = 1'b1;
        end
      end
      if (in_st && st_end[ch] == t) ho_end[ch] = t + int'(hold);
      m_str[ch] = (t + 1 <= st_end[ch]);
      if (clr) begin
        m_acc[ch]  = 0;
        m_drop[ch] = 0;
      end else begin
        if (a && m_acc[ch] < CMAX)  m_acc[ch]  = m_acc[ch] + 1;
        if (d && m_drop[ch] < CMAX) m_drop[ch] = m_drop[ch] + 1;
      end
      m_prev[ch] = trig[ch];
    end
    mcyc = mcyc + 1;
  endfunction

  // Inputs are set on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    model_step();
    @(posedge clk250);
    @(negedge clk250);
  endtask

  task automatic do_reset(input logic [NCH-1:0] trig_val);
    @(negedge clk250);
    trig   = trig_val;
    en     = '1;
    retrig = 1'b0;
    clr    = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk250);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trig  = '1;
    repeat (2) @(negedge clk250);
    n_vec++;
    if ({stretched, rise, any_out} !== '0) begin
      n_err++;
      $display("FAIL reset_flags got=%b exp=0", {stretched, rise, any_out});
    end
    n_vec++;
    if ({acc, drop} !== '0) begin
      n_err++;
      $display("FAIL reset_counts got=%h exp=0", {acc, drop});
    end
  endtask

  task automatic test_single_pulse();
    do_reset('0);
    len  = 5;
    hold = 0;
    for (int c = 0; c < 20; c++) begin
      trig = (c == 10) ? 4'b0001 : 4'b0000;
      tick();
      n_vec++;
      if (stretched[0] !== (c + 1 >= 11 && c + 1 <= 15)) begin
        n_err++;
        $display("FAIL single_stretch cyc=%0d got=%b", c + 1, stretched[0]);
      end
      n_vec++;
      if (rise[0] !== (c + 1 == 11)) begin
        n_err++;
        $display("FAIL single_rise cyc=%0d got=%b", c + 1, rise[0]);
      end
      n_vec++;
      if (any_out !== (c + 1 >= 12 && c + 1 <= 16)) begin
        n_err++;
        $display("FAIL single_any cyc=%0d got=%b", c + 1, any_out);
      end
    end
    n_vec++;
    if (acc[CW-1:0] !== CW'(1) || drop[CW-1:0] !== CW'(0)) begin
      n_err++;
      $display("FAIL single_counts acc=%0d drop=%0d exp acc=1 drop=0", acc[CW-1:0], drop[CW-1:0]);
    end
  endtask

  task automatic test_holdoff();
    do_reset('0);
    len  = 4;
    hold = 3;
    for (int c = 0; c < 26; c++) begin
      trig[0] = (c == 10 || c == 13 || c == 16 || c == 18);
      tick();
      n_vec++;
      if (stretched[0] !== ((c + 1 >= 11 && c + 1 <= 14) || (c + 1 >= 19 && c + 1 <= 22))) begin
        n_err++;
        $display("FAIL holdoff_stretch cyc=%0d got=%b", c + 1, stretched[0]);
      end
      n_vec++;
      if (rise[0] !== (c + 1 == 11 || c + 1 == 19)) begin
        n_err++;
        $display("FAIL holdoff_rise cyc=%0d got=%b", c + 1, rise[0]);
      end
      if (c == 17) begin
        n_vec++;
        if (acc[CW-1:0] !== CW'(1) || drop[CW-1:0] !== CW'(2)) begin
          n_err++;
          $display("FAIL holdoff_mid_counts acc=%0d drop=%0d exp 1/2", acc[CW-1:0], drop[CW-1:0]);
        end
      end
    end
    n_vec++;
    if (acc[CW-1:0] !== CW'(2) || drop[CW-1:0] !== CW'(2)) begin
      n_err++;
      $display("FAIL holdoff_counts acc=%0d drop=%0d exp 2/2", acc[CW-1:0], drop[CW-1:0]);
    end
  endtask

  task automatic test_retrig();
    do_reset('0);
    len    = 4;
    hold   = 0;
    retrig = 1'b1;
    for (int c = 0; c < 22; c++) begin
      trig[0] = (c == 10 || c == 13);
      tick();
      n_vec++;
      if (stretched[0] !== (c + 1 >= 11 && c + 1 <= 17)) begin
        n_err++;
        $display("FAIL retrig_stretch cyc=%0d got=%b", c + 1, stretched[0]);
      end
      n_vec++;
      if (rise[0] !== (c + 1 == 11)) begin
        n_err++;
        $display("FAIL retrig_rise cyc=%0d got=%b", c + 1, rise[0]);
      end
    end
    n_vec++;
    if (acc[CW-1:0] !== CW'(2)) begin
      n_err++;
      $display("FAIL retrig_acc got=%0d exp=2", acc[CW-1:0]);
    end
  endtask

  task automatic test_toggle();
    do_reset('0);
    len  = 0;
    hold = 0;
    for (int c = 0; c < 20; c++) begin
      trig[0] = (c % 2 == 1);
      tick();
      n_vec++;
      if (stretched[0] !== (c % 2 == 1)) begin
        n_err++;
        $display("FAIL toggle_stretch cyc=%0d got=%b", c + 1, stretched[0]);
      end
    end
    n_vec++;
    if (acc[CW-1:0] !== CW'(10)) begin
      n_err++;
      $display("FAIL toggle_acc got=%0d exp=10", acc[CW-1:0]);
    end
  endtask

  task automatic test_trig_during_reset();
    int highs;
    highs = 0;
    do_reset(4'b0001);
    len  = 3;
    hold = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (stretched[0]) highs++;
      n_vec++;
      if (stretched[0] !== (c + 1 >= 1 && c + 1 <= 3)) begin
        n_err++;
        $display("FAIL held_trig_stretch cyc=%0d got=%b", c + 1, stretched[0]);
      end
    end
    n_vec++;
    if (highs != 3 || acc[CW-1:0] !== CW'(1)) begin
      n_err++;
      $display("FAIL held_trig_pulses highs=%0d acc=%0d exp 3/1", highs, acc[CW-1:0]);
    end
  endtask

  task automatic test_saturate();
    do_reset('0);
    len  = 0;
    hold = 0;
    for (int i = 0; i < CMAX - 1; i++) begin
      trig[0] = 1'b1;
      tick();
      trig[0] = 1'b0;
      tick();
    end
    n_vec++;
    if (acc[CW-1:0] !== CW'(CMAX - 1)) begin
      n_err++;
      $display("FAIL sat_preload got=%0d exp=%0d", acc[CW-1:0], CMAX - 1);
    end
    for (int k = 0; k < 3; k++) begin
      trig[0] = 1'b1;
      tick();
      n_vec++;
      if (acc[CW-1:0] !== CW'(CMAX)) begin
        n_err++;
        $display("FAIL sat_hold edge=%0d got=%0d exp=%0d", k, acc[CW-1:0], CMAX);
      end
      trig[0] = 1'b0;
      tick();
    end
    trig[0] = 1'b1;
    clr     = 1'b1;
    tick();
    n_vec++;
    if (acc[CW-1:0] !== CW'(0) || stretched[0] !== 1'b1) begin
      n_err++;
      $display("FAIL clr_wins acc=%0d str=%b exp 0/1", acc[CW-1:0], stretched[0]);
    end
    clr     = 1'b0;
    trig[0] = 1'b0;
    tick();
    n_vec++;
    if (acc[CW-1:0] !== CW'(0)) begin
      n_err++;
      $display("FAIL clr_after got=%0d exp=0", acc[CW-1:0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset('0);
    len  = 20;
    hold = 0;
    for (int c = 0; c < 12; c++) begin
      trig[0] = (c == 2);
      tick();
    end
    n_vec++;
    if (stretched[0] !== 1'b1) begin
      n_err++;
      $display("FAIL async_pre got=%b exp=1", stretched[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({stretched, rise, any_out, acc, drop} !== '0) begin
      n_err++;
      $display("FAIL async_clear got=%h exp=0", {stretched, rise, any_out, acc, drop});
    end
    @(negedge clk250);
    trig  = '0;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 26; c++) begin
      trig[0] = (c == 1);
      tick();
      n_vec++;
      if (stretched[0] !== (c + 1 >= 2 && c + 1 <= 21)) begin
        n_err++;
        $display("FAIL async_after cyc=%0d got=%b", c + 1, stretched[0]);
      end
    end
  endtask

  task automatic test_random();
    do_reset('0);
    len    = 3;
    hold   = 2;
    retrig = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      trig = NCH'($urandom) & NCH'($urandom);
      en   = ($urandom_range(0, 3) != 0) ? '1 : NCH'($urandom);
      if ($urandom_range(0, 15) == 0) len = LW'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) hold = LW'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) retrig = ~retrig;
      clr = ($urandom_range(0, 199) == 0);
      tick();
      for (int ch = 0; ch < NCH; ch++) begin
        n_vec++;
        if (stretched[ch] !== m_str[ch] || rise[ch] !== m_rise[ch]) begin
          n_err++;
          $display("FAIL rand_flags cyc=%0d ch=%0d str=%b rise=%b exp %b/%b",
                   c, ch, stretched[ch], rise[ch], m_str[ch], m_rise[ch]);
        end
        n_vec++;
        if (acc[ch*CW +: CW] !== CW'(m_acc[ch]) || drop[ch*CW +: CW] !== CW'(m_drop[ch])) begin
          n_err++;
          $display("FAIL rand_counts cyc=%0d ch=%0d acc=%0d drop=%0d exp %0d/%0d",
                   c, ch, acc[ch*CW +: CW], drop[ch*CW +: CW], m_acc[ch], m_drop[ch]);
        end
      end
      n_vec++;
      if (any_out !== m_any) begin
        n_err++;
        $display("FAIL rand_any cyc=%0d got=%b exp=%b", c, any_out, m_any);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pulse();
    test_holdoff();
    test_retrig();
    test_toggle();
    test_trig_during_reset();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
